// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: CHUNK bits resolved per stage,
// carry registered between stages, valid/ready handshake with full backpressure.
module pipelined_add_sub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int STAGES = WIDTH / CHUNK;

   // acc_p[k] holds resolved sum slices 0..k; the slices above still carry operand A
   logic [WIDTH-1:0] acc_p [STAGES];
   logic [WIDTH-1:0] bb_p  [STAGES];
   logic             cy_p  [STAGES];
   logic             am_p  [STAGES];
   logic             bm_p  [STAGES];
   logic             vld_p [STAGES];
   logic             ovf_p;

   logic [WIDTH-1:0] acc_in [STAGES];
   logic [WIDTH-1:0] bb_in  [STAGES];
   logic             cy_in  [STAGES];
   logic             am_in  [STAGES];
   logic             bm_in  [STAGES];
   logic             vld_in [STAGES];
   logic [WIDTH-1:0] acc_nx [STAGES];
   logic             cy_nx  [STAGES];
   logic [CHUNK:0]   slice_sum [STAGES];
   logic             ovf_nx;
   logic             stall;

   assign stall     = vld_p[STAGES-1] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = vld_p[STAGES-1];
   assign result    = acc_p[STAGES-1];
   assign carry_out = cy_p[STAGES-1];
   assign overflow  = ovf_p;

   always_comb begin
      acc_in[0] = op_a;
      bb_in[0]  = op_b ^ {WIDTH{sub}};
      cy_in[0]  = sub;
      am_in[0]  = op_a[WIDTH-1];
      bm_in[0]  = op_b[WIDTH-1] ^ sub;
      vld_in[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         acc_in[k] = acc_p[k-1];
         bb_in[k]  = bb_p[k-1];
         cy_in[k]  = cy_p[k-1];
         am_in[k]  = am_p[k-1];
         bm_in[k]  = bm_p[k-1];
         vld_in[k] = vld_p[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         slice_sum[k] = {1'b0, acc_in[k][k*CHUNK +: CHUNK]}
                      + {1'b0, bb_in[k][k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, cy_in[k]};
         acc_nx[k] = acc_in[k];
         acc_nx[k][k*CHUNK +: CHUNK] = slice_sum[k][CHUNK-1:0];
         cy_nx[k] = slice_sum[k][CHUNK];
      end
      ovf_nx = (am_in[STAGES-1] == bm_in[STAGES-1])
             & (acc_nx[STAGES-1][WIDTH-1] != am_in[STAGES-1]);
   end

   // Stage registers: every stage holds while the output is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            acc_p[k] <= '0;
            bb_p[k]  <= '0;
            cy_p[k]  <= 1'b0;
            am_p[k]  <= 1'b0;
            bm_p[k]  <= 1'b0;
            vld_p[k] <= 1'b0;
         end
         ovf_p <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            acc_p[k] <= acc_nx[k];
            bb_p[k]  <= bb_in[k];
            cy_p[k]  <= cy_nx[k];
            am_p[k]  <= am_in[k];
            bm_p[k]  <= bm_in[k];
            vld_p[k] <= vld_in[k];
         end
         ovf_p <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: directed and random operations
// against an arithmetic reference model, with stall, drain and reset scenarios.
module tb_pipelined_add_sub;

   localparam int WIDTH  = 8;
   localparam int CHUNK  = 4;
   localparam int STAGES = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] op_a = '0;
   logic [WIDTH-1:0] op_b = '0;
   logic             sub = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic             co;
      logic             ov;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   pipelined_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Reference: unsigned result/carry and signed overflow from plain integer arithmetic
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s);
      exp_t              e;
      longint unsigned   ua, ub, m, res;
      longint            sa, sb, sr;
      ua = a;
      ub = b;
      m  = 64'd1 << WIDTH;
      if (s) begin
         res  = (ua + m - ub) % m;
         e.co = (ua >= ub);
      end else begin
         res  = (ua + ub) % m;
         e.co = ((ua + ub) >= m);
      end
      e.r  = WIDTH'(res);
      sa   = (ua >= m / 2) ? longint'(ua) - longint'(m) : longint'(ua);
      sb   = (ub >= m / 2) ? longint'(ub) - longint'(m) : longint'(ub);
      sr   = s ? sa - sb : sa + sb;
      e.ov = (sr > longint'(m / 2) - 1) || (sr < -longint'(m / 2));
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, sample at negedge, update model, advance.
   // exp_v: -1 = don't care, else required out_valid.
   task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic ordy, input int exp_v, output logic acc);
      exp_t e;
      in_valid  = v;
      op_a      = a;
      op_b      = b;
      sub       = s;
      out_ready = ordy;
      @(negedge clk);
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (exp_v >= 0) chk("out_valid", out_valid, exp_v[0]);
      if (out_valid) begin
         chk("out_expected", q.size() > 0, 1'b1);
         if (q.size() > 0) begin
            e = q[0];
            chk("result", result, e.r);
            chk("carry_out", carry_out, e.co);
            chk("overflow", overflow, e.ov);
            if (out_ready) void'(q.pop_front());
         end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(a, b, s));
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic ordy);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, a, b, s, ordy, -1, acc);
      chk("accept", acc, 1'b1);
   endtask

   task automatic idle(input int n, input logic ordy);
      logic acc;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, ordy, -1, acc);
   endtask

   initial begin
      logic             acc;
      logic [WIDTH-1:0] ra, rb;
      logic             rs;
      int               naccept;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, '0);
      chk("rst_carry", carry_out, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;

      // Directed: 0x37+0x5A with latency check
      cycle(1'b1, WIDTH'(8'h37), WIDTH'(8'h5A), 1'b0, 1'b1, 0, acc);
      chk("accept_first", acc, 1'b1);
      for (int i = 1; i <= STAGES; i++)
         cycle(1'b0, '0, '0, 1'b0, 1'b1, (i == STAGES) ? 1 : 0, acc);
      chk("drain_first", q.size(), 0);

      // Directed carry/borrow/overflow corners
      issue(WIDTH'(8'hFF), WIDTH'(8'h01), 1'b0, 1'b1);
      issue(WIDTH'(8'h10), WIDTH'(8'h20), 1'b1, 1'b1);
      issue(WIDTH'(8'h80), WIDTH'(8'h01), 1'b1, 1'b1);
      issue(WIDTH'(8'h05), WIDTH'(8'h05), 1'b1, 1'b1);
      issue({1'b1, {(WIDTH-1){1'b0}}}, {1'b1, {(WIDTH-1){1'b0}}}, 1'b0, 1'b1);
      issue({1'b0, {(WIDTH-1){1'b1}}}, {(WIDTH){1'b1}}, 1'b1, 1'b1);
      idle(STAGES, 1'b1);
      chk("drain_directed", q.size(), 0);

      // 16 back-to-back random ops at full throughput
      naccept = 0;
      for (int i = 0; i < 16; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rs = 1'($urandom);
         cycle(1'b1, ra, rb, rs, 1'b1, -1, acc);
         if (acc) naccept++;
      end
      chk("b2b_accepted", naccept, 16);
      idle(STAGES, 1'b1);
      chk("b2b_drained", q.size(), 0);

      // Backpressure: fill the pipe, stall 5 cycles, then drain
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom);
      for (int i = 0; i < STAGES + 5; i++) begin
         cycle(1'b1, ra, rb, rs, 1'b0, (i >= STAGES) ? 1 : -1, acc);
         if (acc) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
         end
      end
      chk("stall_held", q.size(), STAGES);
      idle(STAGES, 1'b1);
      chk("stall_drained", q.size(), 0);

      // Random valid/ready mix
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom);
      for (int i = 0; i < 60; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), ra, rb, rs, 1'($urandom_range(0, 2) != 0), -1, acc);
         if (acc) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
         end
      end
      idle(STAGES + 2, 1'b1);
      chk("mix_drained", q.size(), 0);

      // Asynchronous reset with two ops in flight
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b1);
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2 * STAGES + 1; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 0, acc);

      // Pipeline usable again after reset
      issue(WIDTH'(8'h37), WIDTH'(8'h5A), 1'b1, 1'b1);
      idle(STAGES, 1'b1);
      chk("post_rst_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
